// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and fills the IF/ID slot.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets raise a slot fault instead of being rounded down.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        if_misalign,
    input  logic        id_ready
);
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN, FAULT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_nxt;
    logic [31:0] pc, req_pc;
    logic        fault_pend;
    logic [31:0] tgt;
    logic        tgt_mis;
    logic        grant;
    logic        in_flight;

`ifdef IF_MISALIGN_TRAP_EN
    assign tgt     = redirect_pc;
    assign tgt_mis = (redirect_pc[1:0] != 2'b00);
`else
    assign tgt     = {redirect_pc[31:2], 2'b00};
    assign tgt_mis = 1'b0;
    logic unused_low;
    assign unused_low = &{1'b0, redirect_pc[1:0]};
`endif

    assign imem_req    = (state == FETCH) && (!if_valid || id_ready);
    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign grant       = imem_req && imem_gnt;

    // A response is still owed by memory unless it arrives in this very cycle.
    assign in_flight = ((state == FETCH) && grant) ||
                       (((state == WAIT) || (state == DRAIN)) && !imem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            if (in_flight)    state_nxt = DRAIN;
            else if (tgt_mis) state_nxt = FAULT;
            else              state_nxt = FETCH;
        end else begin
            case (state)
                FETCH:   if (grant)       state_nxt = WAIT;
                WAIT:    if (imem_rvalid) state_nxt = FETCH;
                DRAIN:   if (imem_rvalid) state_nxt = fault_pend ? FAULT : FETCH;
                FAULT:   state_nxt = FAULT;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_pc      <= 32'h0;
            fault_pend  <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0;
            if_instr    <= NOP;
            if_misalign <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect flushes decode too, so the slot is dropped even on a same-cycle transfer.
            pc          <= tgt;
            fault_pend  <= tgt_mis;
            if_valid    <= tgt_mis;
            if_misalign <= tgt_mis;
            if (tgt_mis) begin
                if_pc    <= tgt;
                if_instr <= NOP;
            end
        end else begin
            if (if_valid && id_ready) begin
                if_valid    <= 1'b0;
                if_misalign <= 1'b0;
            end
            if (grant) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end
            if ((state == WAIT) && imem_rvalid) begin
                if_valid    <= 1'b1;
                if_pc       <= req_pc;
                if_instr    <= imem_rdata;
                if_misalign <= 1'b0;
            end
            if ((state == DRAIN) && imem_rvalid) fault_pend <= 1'b0;
        end
    end
endmodule
